// File: rtl/gamepad_poller.sv
// SNES-style serial gamepad scanner: latches two pads, clocks 16 bits out of each
// in parallel and publishes both button words together when a scan completes.
module gamepad_poller #(
    parameter int LATCH_CYCLES = 240,
    parameter int HALF_PERIOD  = 120,
    parameter int BUTTONS      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        start,
    input  logic        clear_overrun,
    input  logic        pad_p1_data,
    input  logic        pad_p2_data,
    output logic        gamepad_clk,
    output logic        gamepad_latch,
    output logic [15:0] p1_buttons,
    output logic [15:0] p2_buttons,
    output logic        busy,
    output logic        done,
    output logic        overrun
);

    localparam int CNT_MAX = (LATCH_CYCLES > HALF_PERIOD) ? LATCH_CYCLES : HALF_PERIOD;
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [CW-1:0] LATCH_LOAD = CW'(LATCH_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LOAD  = CW'(HALF_PERIOD - 1);
    localparam logic [3:0]    LAST_BIT   = 4'(BUTTONS - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LATCH  = 2'd1;
    localparam logic [1:0] ST_CLK_LO = 2'd2;
    localparam logic [1:0] ST_CLK_HI = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [3:0]         bit_q, bit_d;
    logic [BUTTONS-1:0] sh1_q, sh1_d;
    logic [BUTTONS-1:0] sh2_q, sh2_d;
    logic [BUTTONS-1:0] p1_q, p1_d;
    logic [BUTTONS-1:0] p2_q, p2_d;
    logic               clk_q, clk_d;
    logic               latch_q, latch_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ovr_q, ovr_d;
    logic               start_prev_q;
    logic               p1_meta_q, p1_sync_q;
    logic               p2_meta_q, p2_sync_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh1_d   = sh1_q;
        sh2_d   = sh2_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        clk_d   = clk_q;
        latch_d = latch_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q;

        case (state_q)
            ST_IDLE: begin
                if (enable && start) begin
                    state_d = ST_LATCH;
                    latch_d = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = LATCH_LOAD;
                end
            end
            ST_LATCH: begin
                if (cnt_q == '0) begin
                    state_d = ST_CLK_LO;
                    latch_d = 1'b0;
                    clk_d   = 1'b0;
                    cnt_d   = HALF_LOAD;
                    bit_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_CLK_LO: begin
                if (cnt_q == '0) begin
                    // Pads drive active-low data; store 1 = pressed.
                    sh1_d[bit_q] = ~p1_sync_q;
                    sh2_d[bit_q] = ~p2_sync_q;
                    state_d      = ST_CLK_HI;
                    clk_d        = 1'b1;
                    cnt_d        = HALF_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_CLK_HI: begin
                if (cnt_q == '0) begin
                    if (bit_q == LAST_BIT) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        p1_d    = sh1_q;
                        p2_d    = sh2_q;
                    end else begin
                        state_d = ST_CLK_LO;
                        clk_d   = 1'b0;
                        cnt_d   = HALF_LOAD;
                        bit_d   = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort wins over any phase progress, and never publishes a partial scan.
        if (!enable && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            clk_d   = 1'b1;
            latch_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            p1_d    = p1_q;
            p2_d    = p2_q;
        end

        // A held start is one request; only a fresh assertion during a scan overruns.
        if (start && !start_prev_q && state_q != ST_IDLE) begin
            ovr_d = 1'b1;
        end else if (clear_overrun) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_q        <= 4'd0;
            sh1_q        <= '0;
            sh2_q        <= '0;
            p1_q         <= '0;
            p2_q         <= '0;
            clk_q        <= 1'b1;
            latch_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ovr_q        <= 1'b0;
            start_prev_q <= 1'b0;
            p1_meta_q    <= 1'b1;
            p1_sync_q    <= 1'b1;
            p2_meta_q    <= 1'b1;
            p2_sync_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            sh1_q        <= sh1_d;
            sh2_q        <= sh2_d;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
            clk_q        <= clk_d;
            latch_q      <= latch_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ovr_q        <= ovr_d;
            start_prev_q <= start;
            p1_meta_q    <= pad_p1_data;
            p1_sync_q    <= p1_meta_q;
            p2_meta_q    <= pad_p2_data;
            p2_sync_q    <= p2_meta_q;
        end
    end

    assign gamepad_clk   = clk_q;
    assign gamepad_latch = latch_q;
    assign p1_buttons    = p1_q;
    assign p2_buttons    = p2_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign overrun       = ovr_q;

endmodule

// File: tb/tb_gamepad_poller.sv
// Directed bench for gamepad_poller with a behavioural shift-register pad model
// (LATCH_CYCLES=4, HALF_PERIOD=4, so a scan keeps busy high for 132 cycles).
module tb_gamepad_poller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        start = 1'b0;
    logic        clear_overrun = 1'b0;
    logic        pad_p1_data;
    logic        pad_p2_data;
    logic        gamepad_clk;
    logic        gamepad_latch;
    logic [15:0] p1_buttons;
    logic [15:0] p2_buttons;
    logic        busy;
    logic        done;
    logic        overrun;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    gamepad_poller #(.LATCH_CYCLES(4), .HALF_PERIOD(4), .BUTTONS(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .start(start),
        .clear_overrun(clear_overrun), .pad_p1_data(pad_p1_data), .pad_p2_data(pad_p2_data),
        .gamepad_clk(gamepad_clk), .gamepad_latch(gamepad_latch),
        .p1_buttons(p1_buttons), .p2_buttons(p2_buttons),
        .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pad model: latch reloads bit 0, each gamepad_clk rise presents the next bit.
    logic [15:0] p1_pat = 16'h0000;
    logic [15:0] p2_pat = 16'h0000;
    int pad_idx = 0;
    always @(posedge gamepad_clk or posedge gamepad_latch) begin
        if (gamepad_latch) pad_idx <= 0;
        else               pad_idx <= pad_idx + 1;
    end
    assign pad_p1_data = (pad_idx < 16) ? ~p1_pat[pad_idx[3:0]] : 1'b1;
    assign pad_p2_data = (pad_idx < 16) ? ~p2_pat[pad_idx[3:0]] : 1'b1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Starts in the first busy cycle; returns in the first cycle with busy low.
    task automatic measure_scan(output int busy_n, output int latch_n,
                                output int falls, output int early_done);
        logic prev;
        busy_n = 0; latch_n = 0; falls = 0; early_done = 0;
        prev = gamepad_clk;
        for (int i = 0; i < 1000 && busy === 1'b1; i++) begin
            busy_n++;
            if (gamepad_latch === 1'b1) latch_n++;
            if (prev === 1'b1 && gamepad_clk === 1'b0) falls++;
            if (done === 1'b1) early_done++;
            prev = gamepad_clk;
            tick();
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        checks++; if (gamepad_clk !== 1'b1) begin failures++; $display("FAIL reset_clk got=%0b exp=1", gamepad_clk); end
        checks++; if (gamepad_latch !== 1'b0) begin failures++; $display("FAIL reset_latch got=%0b exp=0", gamepad_latch); end
        checks++; if (p1_buttons !== 16'h0000) begin failures++; $display("FAIL reset_p1 got=%h exp=0000", p1_buttons); end
        checks++; if (p2_buttons !== 16'h0000) begin failures++; $display("FAIL reset_p2 got=%h exp=0000", p2_buttons); end
        checks++; if ({busy, done, overrun} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {busy, done, overrun}); end
        reset = 1'b0;
        tick();
        checks++; if ({busy, gamepad_latch, gamepad_clk} !== 3'b001) begin failures++; $display("FAIL idle_after_reset got=%b exp=001", {busy, gamepad_latch, gamepad_clk}); end
    endtask

    task automatic test_single_scan;
        int bn, ln, fn, ed;
        p1_pat = 16'h5A3C;
        p2_pat = 16'h0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if ({busy, gamepad_latch} !== 2'b11) begin failures++; $display("FAIL scan_first_cycle got=%b exp=11", {busy, gamepad_latch}); end
        measure_scan(bn, ln, fn, ed);
        checks++; if (bn != 132) begin failures++; $display("FAIL scan_busy_len got=%0d exp=132", bn); end
        checks++; if (ln != 4) begin failures++; $display("FAIL scan_latch_len got=%0d exp=4", ln); end
        checks++; if (fn != 16) begin failures++; $display("FAIL scan_clk_falls got=%0d exp=16", fn); end
        checks++; if (ed != 0) begin failures++; $display("FAIL scan_early_done got=%0d exp=0", ed); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL scan_done got=%0b exp=1", done); end
        checks++; if (p1_buttons !== 16'h5A3C) begin failures++; $display("FAIL scan_p1 got=%h exp=5a3c", p1_buttons); end
        checks++; if (p2_buttons !== 16'h0000) begin failures++; $display("FAIL scan_p2 got=%h exp=0000", p2_buttons); end
        tick();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL scan_done_width got=%0b exp=0", done); end
    endtask

    task automatic test_overrun;
        int n;
        logic ov21, ov31, ov41;
        ov21 = 1'bx; ov31 = 1'bx; ov41 = 1'bx;
        p1_pat = 16'hC35A;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        for (int i = 0; i < 1000 && busy === 1'b1; i++) begin
            n++;
            if (i == 21) ov21 = overrun;
            if (i == 31) ov31 = overrun;
            if (i == 41) ov41 = overrun;
            start = (i == 20 || i == 40);
            clear_overrun = (i == 30 || i == 40);
            tick();
        end
        start = 1'b0;
        clear_overrun = 1'b0;
        checks++; if (n != 132) begin failures++; $display("FAIL ovr_busy_len got=%0d exp=132", n); end
        checks++; if (ov21 !== 1'b1) begin failures++; $display("FAIL ovr_set got=%0b exp=1", ov21); end
        checks++; if (ov31 !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%0b exp=0", ov31); end
        checks++; if (ov41 !== 1'b1) begin failures++; $display("FAIL ovr_set_wins got=%0b exp=1", ov41); end
        checks++; if (done !== 1'b1 || p1_buttons !== 16'hC35A) begin failures++; $display("FAIL ovr_scan_result done=%0b p1=%h exp done=1 p1=c35a", done, p1_buttons); end
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_final_clear got=%0b exp=0", overrun); end
    endtask

    task automatic test_enable_abort;
        int n;
        int dones;
        p1_pat = 16'h1234;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        for (int i = 0; i < 1000 && busy === 1'b1; i++) begin
            n++;
            if (i == 50) enable = 1'b0;
            tick();
        end
        checks++; if (n != 51) begin failures++; $display("FAIL abort_busy_len got=%0d exp=51", n); end
        checks++; if ({gamepad_clk, gamepad_latch, done} !== 3'b100) begin failures++; $display("FAIL abort_pins got=%b exp=100", {gamepad_clk, gamepad_latch, done}); end
        checks++; if (p1_buttons !== 16'hC35A) begin failures++; $display("FAIL abort_p1_kept got=%h exp=c35a", p1_buttons); end
        // start while disabled in IDLE must do nothing at all
        start = 1'b1;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        start = 1'b0;
        checks++; if (dones != 0 || overrun !== 1'b0) begin failures++; $display("FAIL disabled_start activity=%0d ovr=%0b exp 0 0", dones, overrun); end
        enable = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_scan;
        int bn, ln, fn, ed;
        p1_pat = 16'h00FF;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 70; i++) begin
            start = (i == 10);
            tick();
        end
        start = 1'b0;
        checks++; if (overrun !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL rst_pre ovr=%0b busy=%0b exp 1 1", overrun, busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if ({busy, done, overrun, gamepad_latch, gamepad_clk} !== 5'b00001) begin failures++; $display("FAIL rst_mid_flags got=%b exp=00001", {busy, done, overrun, gamepad_latch, gamepad_clk}); end
        checks++; if (p1_buttons !== 16'h0000 || p2_buttons !== 16'h0000) begin failures++; $display("FAIL rst_mid_buttons got=%h/%h exp=0000/0000", p1_buttons, p2_buttons); end
        start = 1'b1;
        tick();
        start = 1'b0;
        measure_scan(bn, ln, fn, ed);
        checks++; if (bn != 132 || done !== 1'b1) begin failures++; $display("FAIL rst_rescan busy=%0d done=%0b exp 132 1", bn, done); end
        checks++; if (p1_buttons !== 16'h00FF) begin failures++; $display("FAIL rst_rescan_p1 got=%h exp=00ff", p1_buttons); end
        tick();
    endtask

    task automatic test_back_to_back;
        logic [15:0] pats1 [3];
        logic [15:0] pats2 [3];
        int bn, ln, fn, ed;
        int last_done;
        pats1[0] = 16'hFFFF; pats1[1] = 16'h0001; pats1[2] = 16'h8000;
        pats2[0] = 16'hC001; pats2[1] = 16'h7FFE; pats2[2] = 16'h0000;
        last_done = -1;
        p1_pat = pats1[0];
        p2_pat = pats2[0];
        start = 1'b1;
        tick();
        for (int s = 0; s < 3; s++) begin
            measure_scan(bn, ln, fn, ed);
            checks++; if (done !== 1'b1 || bn != 132) begin failures++; $display("FAIL b2b_len scan=%0d busy=%0d done=%0b exp 132 1", s, bn, done); end
            checks++; if (p1_buttons !== pats1[s] || p2_buttons !== pats2[s]) begin failures++; $display("FAIL b2b_buttons scan=%0d got=%h/%h exp=%h/%h", s, p1_buttons, p2_buttons, pats1[s], pats2[s]); end
            checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun scan=%0d got=%0b exp=0", s, overrun); end
            if (last_done >= 0) begin
                checks++; if (cyc - last_done != 133) begin failures++; $display("FAIL b2b_period scan=%0d got=%0d exp=133", s, cyc - last_done); end
            end
            last_done = cyc;
            if (s < 2) begin
                p1_pat = pats1[s+1];
                p2_pat = pats2[s+1];
            end else begin
                start = 1'b0;
            end
            tick();
            if (s < 2) begin
                checks++; if ({busy, gamepad_latch} !== 2'b11) begin failures++; $display("FAIL b2b_restart scan=%0d got=%b exp=11", s, {busy, gamepad_latch}); end
            end
        end
        checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL b2b_stop got=%b exp=00", {busy, done}); end
    endtask

    initial begin
        test_reset();
        test_single_scan();
        test_overrun();
        test_enable_abort();
        test_reset_mid_scan();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
